ad5543_driver: RTL and testbench



---
 rtl/ad5543_driver.sv | 177 +++++++++++++++++
 tb/tb_ad5543_driver.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad5543_driver.sv
// ad5543_driver: turns valid/ready samples into AD5543 serial frames
// (sclk idles low, sdi MSB first, cs_n framing, done pulse when cs_n rises).
// Optional feature macro: AD5543_DRV_SKIP_SAME_EN -- when defined, a sample
// equal to the last word sent is accepted without producing a frame.

module ad5543_driver #(
  parameter int DW      = 16,
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic          sclk,
  output logic          sdi,
  output logic          cs_n,
  output logic          busy,
  output logic          done
);

  localparam int PMAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int PW   = $clog2(PMAX) + 1;
  localparam int BW   = $clog2(DW) + 1;

  localparam logic [PW-1:0] DIV_LAST = PW'(CLK_DIV - 1);
  // IDLE also holds cs_n high, so GAP runs one cycle short of CS_GAP
  localparam logic [PW-1:0] GAP_LAST = PW'((CS_GAP > 1) ? CS_GAP - 2 : 0);
  localparam logic [BW-1:0] BITS     = BW'(DW);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, GAP} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DW-2:0] sh_q, sh_d;
  logic          sclk_q, sclk_d;
  logic          sdi_q, sdi_d;
  logic          cs_n_q, cs_n_d;
  logic          done_q, done_d;
  logic          skip_same;

`ifdef AD5543_DRV_SKIP_SAME_EN
  logic [DW-1:0] last_q, last_d;
  logic          none_sent_q, none_sent_d;

  assign skip_same = !none_sent_q && (s_data == last_q);

  // Remember the word behind every frame that actually starts
  always_comb begin
    last_d      = last_q;
    none_sent_d = none_sent_q;
    if (state_q == IDLE && s_valid && !skip_same) begin
      last_d      = s_data;
      none_sent_d = 1'b0;
    end
  end

  // Last-word register, forgotten on reset so the first sample always goes out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q      <= '0;
      none_sent_q <= 1'b1;
    end else begin
      last_q      <= last_d;
      none_sent_q <= none_sent_d;
    end
  end
`else
  assign skip_same = 1'b0;
`endif

  // Frame sequencing: the MSB leaves straight from s_data, the shift register holds the rest
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    sclk_d  = sclk_q;
    sdi_d   = sdi_q;
    cs_n_d  = cs_n_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        phase_d = '0;
        sclk_d  = 1'b0;
        cs_n_d  = 1'b1;
        if (s_valid && !skip_same) begin
          state_d = SETUP;
          sh_d    = s_data[DW-2:0];
          sdi_d   = s_data[DW-1];
          cs_n_d  = 1'b0;
          bit_d   = BITS;
        end
      end
      SETUP: begin
        if (phase_q == DIV_LAST) begin
          phase_d = '0;
          sclk_d  = 1'b1;
          state_d = SHIFT_HI;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      SHIFT_HI: begin
        if (phase_q == DIV_LAST) begin
          phase_d = '0;
          sclk_d  = 1'b0;
          bit_d   = bit_q - BW'(1);
          state_d = SHIFT_LO;
          if (bit_q != BW'(1)) begin
            sdi_d = sh_q[DW-2];
            sh_d  = sh_q << 1;
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      SHIFT_LO: begin
        if (phase_q == DIV_LAST) begin
          phase_d = '0;
          if (bit_q == '0) begin
            cs_n_d  = 1'b1;
            done_d  = 1'b1;
            state_d = (CS_GAP > 1) ? GAP : IDLE;
          end else begin
            sclk_d  = 1'b1;
            state_d = SHIFT_HI;
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      GAP: begin
        if (phase_q == GAP_LAST) begin
          phase_d = '0;
          state_d = IDLE;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered pin drivers; reset parks the DAC pins in their idle levels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      sclk_q  <= 1'b0;
      sdi_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      sclk_q  <= sclk_d;
      sdi_q   <= sdi_d;
      cs_n_q  <= cs_n_d;
      done_q  <= done_d;
    end
  end

  assign s_ready = (state_q == IDLE);
  assign busy    = !s_ready;
  assign sclk    = sclk_q;
  assign sdi     = sdi_q;
  assign cs_n    = cs_n_q;
  assign done    = done_q;

endmodule

// File: tb/tb_ad5543_driver.sv
// tb_ad5543_driver: three driver instances (16/2/2, 8/1/1, 4/5/3) behind a
// shared stimulus bus; a behavioural AD5543 receiver decodes the pins.

module tb_ad5543_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] tb_data;
  logic        tb_valid;
  int          sel;
  int          cur_dw, cur_div, cur_gap;

  int compared   = 0;
  int mismatched = 0;

  logic a_valid, a_ready, a_sclk, a_sdi, a_cs_n, a_busy, a_done;
  logic b_valid, b_ready, b_sclk, b_sdi, b_cs_n, b_busy, b_done;
  logic c_valid, c_ready, c_sclk, c_sdi, c_cs_n, c_busy, c_done;
  logic m_ready, m_sclk, m_sdi, m_cs_n, m_busy, m_done;

  always #5 clk = ~clk;

  assign a_valid = tb_valid && (sel == 0);
  assign b_valid = tb_valid && (sel == 1);
  assign c_valid = tb_valid && (sel == 2);

  ad5543_driver #(.DW(16), .CLK_DIV(2), .CS_GAP(2)) u_a (
    .clk(clk), .rst(rst), .s_data(tb_data), .s_valid(a_valid), .s_ready(a_ready),
    .sclk(a_sclk), .sdi(a_sdi), .cs_n(a_cs_n), .busy(a_busy), .done(a_done));

  ad5543_driver #(.DW(8), .CLK_DIV(1), .CS_GAP(1)) u_b (
    .clk(clk), .rst(rst), .s_data(tb_data[7:0]), .s_valid(b_valid), .s_ready(b_ready),
    .sclk(b_sclk), .sdi(b_sdi), .cs_n(b_cs_n), .busy(b_busy), .done(b_done));

  ad5543_driver #(.DW(4), .CLK_DIV(5), .CS_GAP(3)) u_c (
    .clk(clk), .rst(rst), .s_data(tb_data[3:0]), .s_valid(c_valid), .s_ready(c_ready),
    .sclk(c_sclk), .sdi(c_sdi), .cs_n(c_cs_n), .busy(c_busy), .done(c_done));

  // Route the selected instance onto the monitored pins
  always_comb begin
    m_ready = a_ready; m_sclk = a_sclk; m_sdi = a_sdi;
    m_cs_n  = a_cs_n;  m_busy = a_busy; m_done = a_done;
    case (sel)
      1: begin
        m_ready = b_ready; m_sclk = b_sclk; m_sdi = b_sdi;
        m_cs_n  = b_cs_n;  m_busy = b_busy; m_done = b_done;
      end
      2: begin
        m_ready = c_ready; m_sclk = c_sclk; m_sdi = c_sdi;
        m_cs_n  = c_cs_n;  m_busy = c_busy; m_done = c_done;
      end
      default: ;
    endcase
  end

  // Receiver model: shift sdi on sclk rise while selected, latch on cs_n rise
  logic [15:0] dac_sh      = '0;
  logic [15:0] dac_data    = '0;
  logic [15:0] dac_mask    = 16'hFFFF;
  int          dac_bits    = 0;
  int          dac_latches = 0;

  always @(posedge m_sclk) begin
    if (m_cs_n === 1'b0) begin
      dac_sh = {dac_sh[14:0], m_sdi};
      dac_bits++;
    end
  end

  always @(posedge m_cs_n) begin
    if (dac_bits > 0) begin
      dac_data = dac_sh & dac_mask;
      dac_latches++;
      dac_bits = 0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic selectDut(input int s, input int dw, input int div, input int gap);
    sel      = s;
    cur_dw   = dw;
    cur_div  = div;
    cur_gap  = gap;
    dac_mask = 16'((32'd1 << dw) - 1);
    @(negedge clk);
  endtask

  // Send one sample (called right after a negedge with the DUT idle) and check its frame
  task automatic applyStimulus(input string tag, input logic [15:0] data,
                               input bit keep_valid, input logic [15:0] next_data);
    int rises = 0, low = 0, high = 0, dones = 0, done_k = 0;
    int viol = 0, stable = 1, ready_k = 0, latches0;
    int frame_len;
    logic psclk, psdi;
    logic [15:0] want;
    frame_len = cur_div * (1 + 2 * cur_dw);
    want      = data & dac_mask;
    latches0  = dac_latches;
    tb_data   = data;
    tb_valid  = 1'b1;
    checkOutput({tag, " ready_before"}, 32'(m_ready), 32'd1);
    psclk = m_sclk;
    psdi  = m_sdi;
    @(posedge clk);
    #1;
    if (keep_valid) tb_data = next_data;
    else begin
      tb_valid = 1'b0;
      tb_data  = ~data;
    end
    for (int k = 1; k <= 4 * frame_len + 100 && ready_k == 0; k++) begin
      @(negedge clk);
      if (k == 1) checkOutput({tag, " busy"}, 32'(m_busy), 32'd1);
      if (m_sclk && !psclk) begin
        rises++;
        if (m_sdi !== psdi || stable < cur_div) viol++;
      end
      if (m_sclk && psclk && m_sdi !== psdi) viol++;
      if (m_sclk && m_cs_n) viol++;
      if (m_sdi === psdi) stable++;
      else stable = 1;
      if (!m_cs_n) low++;
      else high++;
      if (m_done) begin
        dones++;
        if (done_k == 0) done_k = k;
      end
      if (m_ready) ready_k = k;
      psclk = m_sclk;
      psdi  = m_sdi;
    end
    if (ready_k == 0) begin
      checkOutput({tag, " timeout"}, 32'd0, 32'd1);
    end else begin
      checkOutput({tag, " sclk_rises"},  32'(rises),  32'(cur_dw));
      checkOutput({tag, " cs_low"},      32'(low),    32'(frame_len));
      checkOutput({tag, " cs_high_gap"}, 32'(high),   32'(cur_gap));
      checkOutput({tag, " done_count"},  32'(dones),  32'd1);
      checkOutput({tag, " done_cycle"},  32'(done_k), 32'(frame_len + 1));
      checkOutput({tag, " next_accept"}, 32'(ready_k), 32'(frame_len + cur_gap));
      checkOutput({tag, " protocol"},    32'(viol),   32'd0);
      checkOutput({tag, " latches"},     32'(dac_latches - latches0), 32'd1);
      checkOutput({tag, " dac_data"},    32'(dac_data), 32'(want));
    end
  endtask

  // Back-to-back random samples, never repeating the previous word
  task automatic runRandom(input string tag, input int n);
    logic [15:0] vals[8];
    logic [15:0] v;
    logic [15:0] prev;
    prev = dac_data;
    for (int i = 0; i < n; i++) begin
      do v = 16'($urandom) & dac_mask; while (v == prev);
      vals[i] = v;
      prev    = v;
    end
    for (int i = 0; i < n; i++)
      applyStimulus($sformatf("%s%0d", tag, i), vals[i], (i + 1 < n), (i + 1 < n) ? vals[i+1] : 16'h0);
  endtask

  initial begin
    int cnt_low, cnt_sclk, cnt_busy, latches0, got;
    rst      = 1'b1;
    tb_valid = 1'b0;
    tb_data  = '0;
    sel      = 0;
    cur_dw   = 16;
    cur_div  = 2;
    cur_gap  = 2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset cs_n",  32'(a_cs_n),  32'd1);
    checkOutput("reset sclk",  32'(a_sclk),  32'd0);
    checkOutput("reset sdi",   32'(a_sdi),   32'd0);
    checkOutput("reset done",  32'(a_done),  32'd0);
    checkOutput("reset ready", 32'(a_ready), 32'd1);
    checkOutput("reset busy",  32'(a_busy),  32'd0);
    checkOutput("reset b_cs_n", 32'(b_cs_n), 32'd1);
    checkOutput("reset c_cs_n", 32'(c_cs_n), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] single frame");
    applyStimulus("single", 16'hA5C3, 1'b0, 16'h0);
    repeat (3) @(negedge clk);

    $display("[TB] back-to-back frames");
    applyStimulus("b2b0", 16'h0000, 1'b1, 16'hFFFF);
    applyStimulus("b2b1", 16'hFFFF, 1'b1, 16'h8001);
    applyStimulus("b2b2", 16'h8001, 1'b0, 16'h0);

    $display("[TB] stall");
    cnt_low = 0; cnt_sclk = 0; cnt_busy = 0;
    latches0 = dac_latches;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!a_cs_n) cnt_low++;
      if (a_sclk) cnt_sclk++;
      if (!a_ready) cnt_busy++;
    end
    checkOutput("stall cs_low",    32'(cnt_low),  32'd0);
    checkOutput("stall sclk_high", 32'(cnt_sclk), 32'd0);
    checkOutput("stall not_ready", 32'(cnt_busy), 32'd0);
    checkOutput("stall latches",   32'(dac_latches - latches0), 32'd0);

    $display("[TB] reset mid-frame");
    tb_data  = 16'h1234;
    tb_valid = 1'b1;
    @(posedge clk);
    #1 tb_valid = 1'b0;
    got = 0;
    for (int k = 0; k < 200 && got == 0; k++) begin
      @(negedge clk);
      if (dac_bits >= 8) got = 1;
    end
    checkOutput("midreset reached_8_bits", 32'(got), 32'd1);
    checkOutput("midreset sclk_high_before", 32'(a_sclk), 32'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("midreset cs_n",  32'(a_cs_n),  32'd1);
    checkOutput("midreset sclk",  32'(a_sclk),  32'd0);
    checkOutput("midreset sdi",   32'(a_sdi),   32'd0);
    checkOutput("midreset done",  32'(a_done),  32'd0);
    checkOutput("midreset ready", 32'(a_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus("after_reset", 16'h4321, 1'b0, 16'h0);
    repeat (2) @(negedge clk);

    $display("[TB] repeated sample");
    applyStimulus("rep0", 16'h00FF, 1'b0, 16'h0);
`ifdef AD5543_DRV_SKIP_SAME_EN
    latches0 = dac_latches;
    tb_data  = 16'h00FF;
    tb_valid = 1'b1;
    checkOutput("rep1 ready_before", 32'(a_ready), 32'd1);
    @(posedge clk);
    #1 tb_valid = 1'b0;
    cnt_low = 0; cnt_busy = 0; got = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!a_cs_n) cnt_low++;
      if (!a_ready) cnt_busy++;
      if (a_done) got++;
    end
    checkOutput("rep1 cs_low",    32'(cnt_low),  32'd0);
    checkOutput("rep1 not_ready", 32'(cnt_busy), 32'd0);
    checkOutput("rep1 done",      32'(got),      32'd0);
    checkOutput("rep1 latches",   32'(dac_latches - latches0), 32'd0);
`else
    applyStimulus("rep1", 16'h00FF, 1'b0, 16'h0);
`endif
    applyStimulus("rep2", 16'h0100, 1'b0, 16'h0);
    repeat (2) @(negedge clk);

    $display("[TB] random frames per instance");
    runRandom("randA_", 4);
    repeat (2) @(negedge clk);
    selectDut(1, 8, 1, 1);
    runRandom("randB_", 6);
    repeat (2) @(negedge clk);
    selectDut(2, 4, 5, 3);
    runRandom("randC_", 4);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
